// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with a registered read port.
// Round-robin in idle, optional ownership locks with a bounded hold time.
module bram_arbiter #(
  parameter  int p_RAM_WIDTH = 8,
  parameter  int p_RAM_DEPTH = 32,
  parameter  int p_LOCK_MAX  = 16,
  localparam int AW          = $clog2(p_RAM_DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req0_valid,
  input  logic [AW-1:0]          in_req0_addr,
  input  logic [p_RAM_WIDTH-1:0] in_req0_wdata,
  input  logic                   i_req0_we,
  input  logic                   i_req0_lock,
  output logic                   o_req0_ready,
  output logic                   o_req0_rvalid,
  output logic [p_RAM_WIDTH-1:0] on_req0_rdata,
  input  logic                   i_req1_valid,
  input  logic [AW-1:0]          in_req1_addr,
  input  logic [p_RAM_WIDTH-1:0] in_req1_wdata,
  input  logic                   i_req1_we,
  input  logic                   i_req1_lock,
  output logic                   o_req1_ready,
  output logic                   o_req1_rvalid,
  output logic [p_RAM_WIDTH-1:0] on_req1_rdata,
  output logic [AW-1:0]          on_ram_addr,
  output logic [p_RAM_WIDTH-1:0] on_ram_datain,
  output logic                   o_ram_wren,
  input  logic [p_RAM_WIDTH-1:0] in_ram_dataout
);

  localparam int CW = (p_LOCK_MAX > 1) ? $clog2(p_LOCK_MAX) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(p_LOCK_MAX - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          grant0, grant1;

  // Grants are held off during reset so ready/wren stay low regardless of the clock.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!i_rst) begin
      case (state_q)
        ST_IDLE: begin
          grant0 = i_req0_valid & (~i_req1_valid | ~prio_q);
          grant1 = i_req1_valid & (~i_req0_valid |  prio_q);
        end
        ST_OWN0: grant0 = i_req0_valid;
        ST_OWN1: grant1 = i_req1_valid;
        default: ;
      endcase
    end
  end

  always_comb begin
    on_ram_addr   = '0;
    on_ram_datain = '0;
    o_ram_wren    = 1'b0;
    if (grant0) begin
      on_ram_addr   = in_req0_addr;
      on_ram_datain = in_req0_wdata;
      o_ram_wren    = i_req0_we;
    end else if (grant1) begin
      on_ram_addr   = in_req1_addr;
      on_ram_datain = in_req1_wdata;
      o_ram_wren    = i_req1_we;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lock_cnt_d = lock_cnt_q;
    rvalid0_d  = grant0 & ~i_req0_we;
    rvalid1_d  = grant1 & ~i_req1_we;
    if (grant0) begin
      prio_d     = 1'b1;
      lock_cnt_d = '0;
      state_d    = i_req0_lock ? ST_OWN0 : ST_IDLE;
    end else if (grant1) begin
      prio_d     = 1'b0;
      lock_cnt_d = '0;
      state_d    = i_req1_lock ? ST_OWN1 : ST_IDLE;
    end else if (state_q != ST_IDLE) begin
      if (lock_cnt_q == LOCK_LAST) begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign o_req0_ready  = grant0;
  assign o_req1_ready  = grant1;
  assign o_req0_rvalid = rvalid0_q;
  assign o_req1_rvalid = rvalid1_q;
  assign on_req0_rdata = in_ram_dataout;
  assign on_req1_rdata = in_ram_dataout;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_bram_arbiter;

  logic       clk, rst, mem_init;
  logic       req0_valid, req0_we, req0_lock, req0_ready, req0_rvalid;
  logic [4:0] req0_addr;
  logic [7:0] req0_wdata, req0_rdata;
  logic       req1_valid, req1_we, req1_lock, req1_ready, req1_rvalid;
  logic [4:0] req1_addr;
  logic [7:0] req1_wdata, req1_rdata;
  logic [4:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic       ram_wren;

  logic [7:0] mem     [32];
  logic [7:0] ref_mem [32];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  bram_arbiter #(.p_RAM_WIDTH(8), .p_RAM_DEPTH(32), .p_LOCK_MAX(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .in_req0_addr(req0_addr), .in_req0_wdata(req0_wdata),
    .i_req0_we(req0_we), .i_req0_lock(req0_lock), .o_req0_ready(req0_ready),
    .o_req0_rvalid(req0_rvalid), .on_req0_rdata(req0_rdata),
    .i_req1_valid(req1_valid), .in_req1_addr(req1_addr), .in_req1_wdata(req1_wdata),
    .i_req1_we(req1_we), .i_req1_lock(req1_lock), .o_req1_ready(req1_ready),
    .o_req1_rvalid(req1_rvalid), .on_req1_rdata(req1_rdata),
    .on_ram_addr(ram_addr), .on_ram_datain(ram_din), .o_ram_wren(ram_wren),
    .in_ram_dataout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered output; location i powers up holding 0x40+i.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(8'h40 + i);
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (req0_rvalid) begin
        if (q0.size() == 0) chk("rvalid0_unexpected", 1, 0);
        else chk("rdata0", {24'b0, req0_rdata}, {24'b0, q0.pop_front()});
      end
      if (req1_rvalid) begin
        if (q1.size() == 0) chk("rvalid1_unexpected", 1, 0);
        else chk("rdata1", {24'b0, req1_rdata}, {24'b0, q1.pop_front()});
      end
    end
  end

  task automatic cyc(input logic v0, input logic [4:0] ad0, input logic [7:0] wd0,
                     input logic w0, input logic lk0,
                     input logic v1, input logic [4:0] ad1, input logic [7:0] wd1,
                     input logic w1, input logic lk1,
                     input logic er0, input logic er1, input string nm);
    logic [4:0] ea;
    logic [7:0] ed;
    logic       ew;
    @(posedge clk);
    #1;
    req0_valid = v0; req0_addr = ad0; req0_wdata = wd0; req0_we = w0; req0_lock = lk0;
    req1_valid = v1; req1_addr = ad1; req1_wdata = wd1; req1_we = w1; req1_lock = lk1;
    @(negedge clk);
    chk({nm, "_ready0"}, {31'b0, req0_ready}, {31'b0, er0});
    chk({nm, "_ready1"}, {31'b0, req1_ready}, {31'b0, er1});
    ea = '0; ed = '0; ew = 1'b0;
    if (er0) begin
      ea = ad0; ed = wd0; ew = w0;
    end else if (er1) begin
      ea = ad1; ed = wd1; ew = w1;
    end
    chk({nm, "_ram_addr"}, {27'b0, ram_addr}, {27'b0, ea});
    chk({nm, "_ram_din"},  {24'b0, ram_din},  {24'b0, ed});
    chk({nm, "_ram_wren"}, {31'b0, ram_wren}, {31'b0, ew});
    if (er0) begin
      if (w0) ref_mem[ad0] = wd0;
      else q0.push_back(ref_mem[ad0]);
    end
    if (er1) begin
      if (w1) ref_mem[ad1] = wd1;
      else q1.push_back(ref_mem[ad1]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(8'h40 + i);
    rst = 1'b1; mem_init = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_wdata = '0; req0_we = 1'b0; req0_lock = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_wdata = '0; req1_we = 1'b0; req1_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", {31'b0, req0_ready}, 0);
    chk("rst_ready1", {31'b0, req1_ready}, 0);
    chk("rst_wren",   {31'b0, ram_wren}, 0);
    chk("rst_rvalid", {30'b0, req0_rvalid, req1_rvalid}, 0);
    req0_valid = 1'b0; req1_valid = 1'b0; mem_init = 1'b0;
    rst = 1'b0;
    idle(1);

    // lone requester 1 granted every cycle
    repeat (3) cyc(0, 0, 0, 0, 0, 1, 5'd2, 0, 0, 0, 0, 1, "single1");
    // both reading every cycle: strict alternation starting with req0
    for (int i = 0; i < 4; i++)
      cyc(1, 5'd3, 0, 0, 0, 1, 5'd5, 0, 0, 0, (i % 2) == 0, (i % 2) == 1, "alt");
    // write 0xA5 to 7 then read it back through the other port
    cyc(1, 5'd7, 8'hA5, 1, 0, 0, 0, 0, 0, 0, 1, 0, "wr7");
    cyc(0, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0, 0, 1, "rd7");
    idle(1);

    // req0 lock with req1 waiting
    cyc(1, 5'd1, 0, 0, 1, 1, 5'd4, 0, 0, 0, 1, 0, "lock0_a");
    cyc(1, 5'd1, 0, 0, 1, 1, 5'd4, 0, 0, 0, 1, 0, "lock0_b");
    cyc(0, 0, 0, 0, 0, 1, 5'd4, 0, 0, 0, 0, 0, "lock0_hold");
    cyc(1, 5'd1, 0, 0, 0, 1, 5'd4, 0, 0, 0, 1, 0, "lock0_rel");
    cyc(1, 5'd1, 0, 0, 0, 1, 5'd4, 0, 0, 0, 0, 1, "after_rel");
    idle(1);

    // req1 lock, relock clears the counter, then forced release after 16 idle cycles
    cyc(0, 0, 0, 0, 0, 1, 5'd6, 0, 0, 1, 0, 1, "lock1");
    repeat (8) cyc(1, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "own1_wait");
    cyc(1, 5'd0, 0, 0, 0, 1, 5'd6, 0, 0, 1, 0, 1, "relock1");
    repeat (16) cyc(1, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "own1_wait2");
    cyc(1, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "forced_rel");
    idle(2);

    // reset between an accepted read and its rvalid; priority must restart at req0
    cyc(1, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "pre_rst");
    @(posedge clk);
    #2;
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("midrst_ready0", {31'b0, req0_ready}, 0);
    chk("midrst_ready1", {31'b0, req1_ready}, 0);
    chk("midrst_wren",   {31'b0, ram_wren}, 0);
    chk("midrst_rvalid0", {31'b0, req0_rvalid}, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    rst = 1'b0;
    void'(q0.pop_back());
    cyc(1, 5'd3, 0, 0, 0, 1, 5'd5, 0, 0, 0, 1, 0, "post_rst_0");
    cyc(1, 5'd3, 0, 0, 0, 1, 5'd5, 0, 0, 0, 0, 1, "post_rst_1");
    idle(3);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
